// File: rtl/cra_pkg.sv
// Shared helpers for the pipelined carry-ripple adder: stage count and
// parameter legality.
package cra_pkg;

    function automatic int unsigned cra_stages(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

    function automatic bit cra_cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/cra_stage.sv
// CHUNK-bit ripple slice. Also exposes the carry into its MSB so the top
// slice can form two's-complement overflow.
module cra_stage
    import cra_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             cmsb_o
);
    logic [CHUNK:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fa u_fa (
            .a_i(a_i[i]),
            .b_i(b_i[i]),
            .c_i(c[i]),
            .s_o(s_o[i]),
            .c_o(c[i+1])
        );
    end

    assign c_o    = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];
endmodule

// File: rtl/fa.sv
// One-bit full adder, the ripple cell of every slice.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/cra_pipe.sv
// Pipelined carry-ripple adder/subtractor: one CHUNK-bit slice per stage,
// carries and skewed operand/sum slices registered between stages.
module cra_pipe
    import cra_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned STAGES = cra_stages(WIDTH, CHUNK);

    if (!cra_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("cra_pipe: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic             en;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Stage k sees only the operand bits not yet summed (REM wide) and the
    // k*CHUNK result bits already produced; stage 0 works straight off the ports.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned REM = WIDTH - k * CHUNK;

        logic [REM-1:0]         a_in, b_in;
        logic                   c_in, v_in;
        logic [CHUNK-1:0]       s_sl;
        logic                   c_out, c_msb;
        logic [(k+1)*CHUNK-1:0] s_out;

        if (k == 0) begin : g_cap
            assign a_in  = a;
            assign b_in  = b ^ {WIDTH{sub}};
            assign c_in  = cin ^ sub;
            assign v_in  = in_valid;
            assign s_out = s_sl;
        end else begin : g_reg
            logic [REM-1:0]       a_q, b_q;
            logic                 c_q, v_q;
            logic [k*CHUNK-1:0]   s_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                    s_q <= '0;
                end else if (en) begin
                    a_q <= g_st[k-1].a_in[REM+CHUNK-1:CHUNK];
                    b_q <= g_st[k-1].b_in[REM+CHUNK-1:CHUNK];
                    c_q <= g_st[k-1].c_out;
                    v_q <= g_st[k-1].v_in;
                    s_q <= g_st[k-1].s_out;
                end
            end

            assign a_in  = a_q;
            assign b_in  = b_q;
            assign c_in  = c_q;
            assign v_in  = v_q;
            assign s_out = {s_sl, s_q};
        end

        cra_stage #(.CHUNK(CHUNK)) u_stage (
            .a_i   (a_in[CHUNK-1:0]),
            .b_i   (b_in[CHUNK-1:0]),
            .c_i   (c_in),
            .s_o   (s_sl),
            .c_o   (c_out),
            .cmsb_o(c_msb)
        );

        // Only the top slice's MSB carry matters (overflow).
        if (k != STAGES - 1) begin : g_mid
            logic c_msb_unused;
            assign c_msb_unused = c_msb;
        end
    end

    assign out_valid_d = g_st[STAGES-1].v_in;
    assign sum_d       = g_st[STAGES-1].s_out;
    assign cout_d      = g_st[STAGES-1].c_out;
    assign ovf_d       = g_st[STAGES-1].c_out ^ g_st[STAGES-1].c_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule
